// File: rtl/video_pkg.sv
// Shared definitions for the scrolling video fetch address generator.
package video_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRESET = 2'd1,
    ST_READY  = 2'd2
  } vstate_e;

  // Character height in lines from its log2 width.
  function automatic int unsigned char_h(input int unsigned chw);
    return 32'd1 << chw;
  endfunction

endpackage

// File: rtl/video_preset_mac.sv
// Iterative accumulator: adds step to a zeroed sum count times, one add per cycle.
module video_preset_mac #(
  parameter int unsigned AW = 21,
  parameter int unsigned CW = 9,
  parameter int unsigned SW = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [CW-1:0] count_i,
  input  logic [SW-1:0] step_i,
  output logic [AW-1:0] sum_o,
  output logic          done_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] sum_q, sum_d;
  logic          done_q, done_d;

  always_comb begin
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    done_d = done_q;
    if (start_i) begin
      cnt_d  = count_i;
      sum_d  = '0;
      done_d = (count_i == '0);
    end else if (cnt_q != '0) begin
      cnt_d  = cnt_q - CW'(1);
      sum_d  = sum_q + AW'(step_i);
      done_d = (cnt_q == CW'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sum_q  <= '0;
      done_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      sum_q  <= sum_d;
      done_q <= done_d;
    end
  end

  assign sum_o  = sum_q;
  assign done_o = done_q;

endmodule

// File: rtl/video_scroll_addrgen.sv
// Video fetch address generator with X/Y hardware scroll, wrap, bitplanes and text rows.
module video_scroll_addrgen
  import video_pkg::*;
#(
  parameter int unsigned AW  = 21,
  parameter int unsigned NPL = 2,
  parameter int unsigned XW  = 7,
  parameter int unsigned YW  = 9,
  parameter int unsigned CHW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_start,
  input  logic              int_start,
  input  logic              vpix,
  input  logic              video_next,
  input  logic [NPL*AW-1:0] cfg_base,
  input  logic [XW-1:0]     cfg_pitch,
  input  logic [XW-1:0]     cfg_xscroll,
  input  logic [YW-1:0]     cfg_yscroll,
  input  logic [YW-1:0]     cfg_height,
  input  logic              cfg_text,
  output logic [AW-1:0]     video_addr,
  output logic [1:0]        video_plane,
  output logic [CHW-1:0]    typos,
  output logic              err_preset
);

  localparam int unsigned CHAR_H = char_h(CHW);
  localparam int unsigned BW     = NPL * AW;

  vstate_e        state_q, state_d;
  logic [BW-1:0]  base_q, base_d;
  logic [XW-1:0]  pitch_q, pitch_d;
  logic [XW-1:0]  xscroll_q, xscroll_d;
  logic [YW-1:0]  height_q, height_d;
  logic           text_q, text_d;
  logic [AW-1:0]  row_off_q, row_off_d;
  logic [YW-1:0]  rowidx_q, rowidx_d;
  logic [XW-1:0]  xi_q, xi_d;
  logic [1:0]     p_q, p_d;
  logic [CHW-1:0] typos_q, typos_d;
  logic           err_q, err_d;
  logic           line_act_q, line_act_d;
  logic [AW-1:0]  addr_q, addr_d;

  logic           line_init;
  logic           load_addr;
  logic [YW-1:0]  yleft_init;
  logic [YW-1:0]  row_init;
  logic [AW-1:0]  mac_sum;
  logic           mac_done;

  function automatic logic [AW-1:0] base_sel(input logic [BW-1:0] b, input logic [1:0] p);
    logic [AW-1:0] r;
    r = '0;
    for (int i = 0; i < NPL; i++) begin
      if (p == 2'(i)) r = b[i*AW +: AW];
    end
    return r;
  endfunction

  assign line_init  = line_start & vpix;
  // Text mode scrolls whole character rows; the sub-line goes to typos.
  assign yleft_init = cfg_text ? YW'(cfg_yscroll >> CHW) : cfg_yscroll;
  assign row_init   = (cfg_height == '0) ? '0 : (yleft_init % cfg_height);

  video_preset_mac #(
    .AW (AW),
    .CW (YW),
    .SW (XW)
  ) u_preset_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (int_start),
    .count_i (yleft_init),
    .step_i  (pitch_q),
    .sum_o   (mac_sum),
    .done_o  (mac_done)
  );

  // Next-state for FSM, shadows, counters and address register.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    pitch_d    = pitch_q;
    xscroll_d  = xscroll_q;
    height_d   = height_q;
    text_d     = text_q;
    row_off_d  = row_off_q;
    rowidx_d   = rowidx_q;
    xi_d       = xi_q;
    p_d        = p_q;
    typos_d    = typos_q;
    err_d      = err_q;
    line_act_d = line_act_q;
    load_addr  = 1'b0;

    if (int_start) begin
      state_d    = ST_PRESET;
      base_d     = cfg_base;
      pitch_d    = cfg_pitch;
      xscroll_d  = cfg_xscroll;
      height_d   = cfg_height;
      text_d     = cfg_text;
      row_off_d  = '0;
      rowidx_d   = row_init;
      typos_d    = cfg_text ? cfg_yscroll[CHW-1:0] : '0;
      err_d      = 1'b0;
      line_act_d = 1'b0;
    end else begin
      case (state_q)
        ST_PRESET: begin
          row_off_d = mac_sum;
          if (mac_done) state_d = ST_READY;
          if (line_init) begin
            err_d     = 1'b1;
            xi_d      = xscroll_q;
            p_d       = '0;
            load_addr = 1'b1;
          end else if (video_next) begin
            load_addr = 1'b1;
          end
        end
        ST_READY: begin
          if (line_init) begin
            line_act_d = 1'b1;
            // The previous line ends here: advance the row before reloading x.
            if (line_act_q) begin
              if (text_q) typos_d = typos_q + CHW'(1);
              if (!text_q || (typos_q == CHW'(CHAR_H - 1))) begin
                if (rowidx_q == YW'(height_q - YW'(1))) begin
                  rowidx_d  = '0;
                  row_off_d = '0;
                end else begin
                  rowidx_d  = rowidx_q + YW'(1);
                  row_off_d = row_off_q + AW'(pitch_q);
                end
              end
            end
            xi_d      = xscroll_q;
            p_d       = '0;
            load_addr = 1'b1;
          end else if (video_next) begin
            load_addr = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // Plane sequence, then horizontal word step with wrap at the pitch.
      if (load_addr && !line_init) begin
        if (p_q == 2'(NPL - 1)) begin
          p_d  = '0;
          xi_d = (xi_q == XW'(pitch_q - XW'(1))) ? '0 : xi_q + XW'(1);
        end else begin
          p_d = p_q + 2'(1);
        end
      end
    end

    addr_d = load_addr ? (base_sel(base_q, p_d) + row_off_d + AW'(xi_d)) : addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      pitch_q    <= '0;
      xscroll_q  <= '0;
      height_q   <= '0;
      text_q     <= 1'b0;
      row_off_q  <= '0;
      rowidx_q   <= '0;
      xi_q       <= '0;
      p_q        <= '0;
      typos_q    <= '0;
      err_q      <= 1'b0;
      line_act_q <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      pitch_q    <= pitch_d;
      xscroll_q  <= xscroll_d;
      height_q   <= height_d;
      text_q     <= text_d;
      row_off_q  <= row_off_d;
      rowidx_q   <= rowidx_d;
      xi_q       <= xi_d;
      p_q        <= p_d;
      typos_q    <= typos_d;
      err_q      <= err_d;
      line_act_q <= line_act_d;
      addr_q     <= addr_d;
    end
  end

  assign video_addr  = addr_q;
  assign video_plane = p_q;
  assign typos       = typos_q;
  assign err_preset  = err_q;

endmodule

// File: tb/tb_video_scroll_addrgen.sv
// Scoreboard bench for video_scroll_addrgen: expected fetch outputs queued per strobe.
module tb_video_scroll_addrgen;

  localparam int unsigned AW  = 21;
  localparam int unsigned NPL = 2;
  localparam int unsigned XW  = 7;
  localparam int unsigned YW  = 9;
  localparam int unsigned CHW = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              line_start = 1'b0;
  logic              int_start = 1'b0;
  logic              vpix = 1'b0;
  logic              video_next = 1'b0;
  logic [NPL*AW-1:0] cfg_base = '0;
  logic [XW-1:0]     cfg_pitch = '0;
  logic [XW-1:0]     cfg_xscroll = '0;
  logic [YW-1:0]     cfg_yscroll = '0;
  logic [YW-1:0]     cfg_height = '0;
  logic              cfg_text = 1'b0;
  logic [AW-1:0]     video_addr;
  logic [1:0]        video_plane;
  logic [CHW-1:0]    typos;
  logic              err_preset;

  typedef struct {
    logic [AW-1:0]  addr;
    logic [1:0]     plane;
    logic [CHW-1:0] typos;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  video_scroll_addrgen #(
    .AW (AW), .NPL (NPL), .XW (XW), .YW (YW), .CHW (CHW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .line_start  (line_start),
    .int_start   (int_start),
    .vpix        (vpix),
    .video_next  (video_next),
    .cfg_base    (cfg_base),
    .cfg_pitch   (cfg_pitch),
    .cfg_xscroll (cfg_xscroll),
    .cfg_yscroll (cfg_yscroll),
    .cfg_height  (cfg_height),
    .cfg_text    (cfg_text),
    .video_addr  (video_addr),
    .video_plane (video_plane),
    .typos       (typos),
    .err_preset  (err_preset)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_cfg(input logic [AW-1:0] b0, input logic [AW-1:0] b1,
                         input logic [XW-1:0] pitch, input logic [XW-1:0] xs,
                         input logic [YW-1:0] ys, input logic [YW-1:0] h, input logic txt);
    cfg_base    = {b1, b0};
    cfg_pitch   = pitch;
    cfg_xscroll = xs;
    cfg_yscroll = ys;
    cfg_height  = h;
    cfg_text    = txt;
  endtask

  // One-cycle strobe, driven from a falling edge; returns on the next falling edge.
  task automatic pulse(input logic ls, input logic vn, input logic is);
    line_start = ls;
    vpix       = ls;
    video_next = vn;
    int_start  = is;
    @(negedge clk);
    line_start = 1'b0;
    vpix       = 1'b0;
    video_next = 1'b0;
    int_start  = 1'b0;
  endtask

  task automatic drain(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty, got addr 0x%0h expected an entry", tag, video_addr);
    end else begin
      e = sb.pop_front();
      check_eq({tag, ".addr"},  32'(video_addr),  32'(e.addr));
      check_eq({tag, ".plane"}, 32'(video_plane), 32'(e.plane));
      check_eq({tag, ".typos"}, 32'(typos),       32'(e.typos));
    end
  endtask

  task automatic xfer(input logic ls, input logic vn, input logic [AW-1:0] a,
                      input logic [1:0] p, input logic [CHW-1:0] t, input string tag);
    exp_t e;
    e.addr  = a;
    e.plane = p;
    e.typos = t;
    sb.push_back(e);
    pulse(ls, vn, 1'b0);
    drain(tag);
  endtask

  task automatic start_frame(input int settle);
    pulse(1'b0, 1'b0, 1'b1);
    repeat (settle) @(negedge clk);
  endtask

  logic [AW-1:0] t2_addr [6];
  logic [1:0]    t2_pl   [6];
  logic [CHW-1:0] t4_ty  [4];
  logic [AW-1:0]  t4_ad  [4];

  initial begin
    t2_addr = '{21'h0C026, 21'h08027, 21'h0C027, 21'h08000, 21'h0C000, 21'h08001};
    t2_pl   = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
    t4_ty   = '{3'd5, 3'd6, 3'd7, 3'd0};
    t4_ad   = '{21'h10050, 21'h10050, 21'h10050, 21'h100A0};

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst.addr",  32'(video_addr),  32'h0);
    check_eq("rst.plane", 32'(video_plane), 32'h0);
    check_eq("rst.typos", 32'(typos),       32'h0);
    check_eq("rst.err",   32'(err_preset),  32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    xfer(1'b1, 1'b0, 21'h0, 2'd0, 3'd0, "idle_line");
    xfer(1'b0, 1'b1, 21'h0, 2'd0, 3'd0, "idle_next");

    // Two planes, x scroll near the pitch end wraps horizontally
    set_cfg(21'h08000, 21'h0C000, 7'd40, 7'd38, 9'd0, 9'd100, 1'b0);
    start_frame(4);
    xfer(1'b1, 1'b0, 21'h08026, 2'd0, 3'd0, "xwrap_l");
    for (int i = 0; i < 6; i++) xfer(1'b0, 1'b1, t2_addr[i], t2_pl[i], 3'd0, $sformatf("xwrap_n%0d", i));
    xfer(1'b0, 1'b1, 21'h0C001, 2'd1, 3'd0, "xwrap_n6");

    // line_init beats video_next: row advance, x reload, plane 0
    xfer(1'b1, 1'b1, 21'h0804E, 2'd0, 3'd0, "line_over_next");

    // int_start beats line_init: no address load, fresh frame restarts at row 0
    pulse(1'b1, 1'b0, 1'b1);
    check_eq("is_over_line.addr", 32'(video_addr), 32'h0804E);
    check_eq("is_over_line.err",  32'(err_preset), 32'h0);
    repeat (4) @(negedge clk);
    xfer(1'b1, 1'b0, 21'h08026, 2'd0, 3'd0, "is_over_line_next");

    // Asynchronous reset during READY
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst.addr",  32'(video_addr),  32'h0);
    check_eq("midrst.plane", 32'(video_plane), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xfer(1'b1, 1'b0, 21'h0, 2'd0, 3'd0, "midrst_line");
    xfer(1'b0, 1'b1, 21'h0, 2'd0, 3'd0, "midrst_next");

    // Vertical scroll with wrap at the window height
    set_cfg(21'h01000, 21'h02000, 7'd32, 7'd0, 9'd3, 9'd4, 1'b0);
    start_frame(10);
    xfer(1'b1, 1'b0, 21'h01060, 2'd0, 3'd0, "ywrap_l0");
    xfer(1'b1, 1'b0, 21'h01000, 2'd0, 3'd0, "ywrap_l1");
    xfer(1'b1, 1'b0, 21'h01020, 2'd0, 3'd0, "ywrap_l2");
    xfer(1'b0, 1'b1, 21'h02020, 2'd1, 3'd0, "ywrap_n");

    // Text mode: row 1, sub-line 5
    set_cfg(21'h10000, 21'h18000, 7'd80, 7'd0, 9'd13, 9'd25, 1'b1);
    start_frame(6);
    for (int i = 0; i < 4; i++) xfer(1'b1, 1'b0, t4_ad[i], 2'd0, t4_ty[i], $sformatf("text_l%0d", i));

    // Visible line arrives during a long preset
    set_cfg(21'h0, 21'h100000, 7'd40, 7'd0, 9'd300, 9'd400, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    repeat (99) @(negedge clk);
    pulse(1'b1, 1'b0, 1'b0);
    check_eq("late.err_set", 32'(err_preset), 32'h1);
    repeat (250) @(negedge clk);
    xfer(1'b1, 1'b0, 21'(300 * 40), 2'd0, 3'd0, "late_final_row");
    check_eq("late.err_sticky", 32'(err_preset), 32'h1);
    pulse(1'b0, 1'b0, 1'b1);
    check_eq("late.err_clear", 32'(err_preset), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
